// File: rtl/parking_gate_driver_if.sv
// Sensor/indicator bundle between the parking-lot vehicle sensors and the barrier driver.
interface parking_gate_driver_if;
    logic       car_in_req;
    logic       car_in_pass;
    logic       car_out_req;
    logic       car_out_pass;
    logic       cancela_entrada;
    logic       cancela_saida;
    logic       motor_in_up;
    logic       motor_in_down;
    logic       motor_out_up;
    logic       motor_out_down;
    logic [3:0] num_carros;
    logic       lot_full;

    modport master (
        output car_in_req, car_in_pass, car_out_req, car_out_pass,
        input  cancela_entrada, cancela_saida, motor_in_up, motor_in_down,
        input  motor_out_up, motor_out_down, num_carros, lot_full
    );

    modport slave (
        input  car_in_req, car_in_pass, car_out_req, car_out_pass,
        output cancela_entrada, cancela_saida, motor_in_up, motor_in_down,
        output motor_out_up, motor_out_down, num_carros, lot_full
    );
endinterface

// File: rtl/parking_gate_driver.sv
// Entry/exit barrier controller: two gate FSMs with travel/hold timing and an occupancy counter.
module parking_gate_driver #(
    parameter int unsigned CAPACITY    = 10,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned HOLD_CYCLES = 8
) (
    input  logic                  clk_2,
    input  logic                  reset,
    parking_gate_driver_if.slave  gate_bus
);

    localparam int unsigned MoveW = $clog2(MOVE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_CYCLES - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
    localparam logic [3:0]       CapCount = 4'(CAPACITY);

    typedef enum logic [1:0] {StClosed, StRaising, StOpen, StLowering} gate_state_e;

    // Index 0 is the entry gate, index 1 the exit gate.
    logic [1:0] req;
    logic [1:0] pass;
    logic [1:0] allow;
    logic [1:0] open_w;
    logic [1:0] up_w;
    logic [1:0] down_w;
    logic [1:0] event_w;
    logic [3:0] num_q;

    assign req   = {gate_bus.car_out_req, gate_bus.car_in_req};
    assign pass  = {gate_bus.car_out_pass, gate_bus.car_in_pass};
    assign allow = {num_q != 4'd0, num_q < CapCount};

    for (genvar g = 0; g < 2; g++) begin : g_gate
        gate_state_e      state_q;
        logic [MoveW-1:0] move_q;
        logic [HoldW-1:0] hold_q;
        logic             pass_q;

        always_ff @(posedge clk_2) begin
            if (reset) begin
                state_q <= StClosed;
                move_q  <= '0;
                hold_q  <= '0;
                pass_q  <= 1'b0;
            end else begin
                pass_q <= pass[g];
                unique case (state_q)
                    StClosed: begin
                        if (req[g] && allow[g]) begin
                            state_q <= StRaising;
                            move_q  <= '0;
                        end
                    end
                    StRaising: begin
                        if (move_q == MoveLast) begin
                            state_q <= StOpen;
                            hold_q  <= '0;
                        end else begin
                            move_q <= move_q + 1'b1;
                        end
                    end
                    StOpen: begin
                        if (req[g] || pass[g]) begin
                            hold_q <= '0;
                        end else if (hold_q == HoldLast) begin
                            state_q <= StLowering;
                            move_q  <= '0;
                        end else begin
                            hold_q <= hold_q + 1'b1;
                        end
                    end
                    StLowering: begin
                        // Anything in the beam while lowering forces a full re-raise.
                        if (pass[g]) begin
                            state_q <= StRaising;
                            move_q  <= '0;
                        end else if (move_q == MoveLast) begin
                            state_q <= StClosed;
                        end else begin
                            move_q <= move_q + 1'b1;
                        end
                    end
                    default: state_q <= StClosed;
                endcase
            end
        end

        assign open_w[g]  = (state_q == StOpen);
        assign up_w[g]    = (state_q == StRaising);
        assign down_w[g]  = (state_q == StLowering);
        assign event_w[g] = open_w[g] & pass_q & ~pass[g];
    end

    // Simultaneous entry and exit passages cancel out.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            num_q <= '0;
        end else begin
            case (event_w)
                2'b01:   if (num_q < CapCount) num_q <= num_q + 1'b1;
                2'b10:   if (num_q != 4'd0) num_q <= num_q - 1'b1;
                default: ;
            endcase
        end
    end

    assign gate_bus.cancela_entrada = open_w[0];
    assign gate_bus.cancela_saida   = open_w[1];
    assign gate_bus.motor_in_up     = up_w[0];
    assign gate_bus.motor_in_down   = down_w[0];
    assign gate_bus.motor_out_up    = up_w[1];
    assign gate_bus.motor_out_down  = down_w[1];
    assign gate_bus.num_carros      = num_q;
    assign gate_bus.lot_full        = (num_q == CapCount);

endmodule

// File: tb/tb_parking_gate_driver.sv
// Self-checking bench for parking_gate_driver: vector table, corner sequences, random vs model.
module tb_parking_gate_driver;

    localparam int Cap  = 10;
    localparam int Move = 4;
    localparam int Hold = 8;

    localparam int PhClosed = 0;
    localparam int PhUp     = 1;
    localparam int PhOpen   = 2;
    localparam int PhDown   = 3;

    logic clk_2 = 1'b0;
    logic reset;

    parking_gate_driver_if gate_bus ();

    parking_gate_driver #(
        .CAPACITY    (Cap),
        .MOVE_CYCLES (Move),
        .HOLD_CYCLES (Hold)
    ) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .gate_bus (gate_bus)
    );

    always #5 clk_2 = ~clk_2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase per gate, cycles left in motion, idle cycles seen while open.
    int m_phase[2] = '{PhClosed, PhClosed};
    int m_left[2]  = '{0, 0};
    int m_idle[2]  = '{0, 0};
    bit m_prev[2]  = '{1'b0, 1'b0};
    int m_count    = 0;

    logic [10:0] dut_outs;
    assign dut_outs = {gate_bus.cancela_entrada, gate_bus.motor_in_up, gate_bus.motor_in_down,
                       gate_bus.cancela_saida, gate_bus.motor_out_up, gate_bus.motor_out_down,
                       gate_bus.num_carros, gate_bus.lot_full};

    typedef struct {
        bit          rst;
        bit          ir;
        bit          ip;
        bit          orq;
        bit          op;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit ir, input bit ip, input bit orq,
                              input bit op);
        bit req[2];
        bit pass[2];
        bit ev[2];
        bit ok;
        req[0] = ir;  req[1] = orq;
        pass[0] = ip; pass[1] = op;
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                m_phase[g] = PhClosed;
                m_left[g]  = 0;
                m_idle[g]  = 0;
                m_prev[g]  = 1'b0;
            end
            m_count = 0;
            return;
        end
        for (int g = 0; g < 2; g++) ev[g] = (m_phase[g] == PhOpen) && m_prev[g] && !pass[g];
        for (int g = 0; g < 2; g++) begin
            case (m_phase[g])
                PhClosed: begin
                    ok = (g == 0) ? (m_count < Cap) : (m_count > 0);
                    if (req[g] && ok) begin
                        m_phase[g] = PhUp;
                        m_left[g]  = Move;
                    end
                end
                PhUp: begin
                    m_left[g]--;
                    if (m_left[g] == 0) begin
                        m_phase[g] = PhOpen;
                        m_idle[g]  = 0;
                    end
                end
                PhOpen: begin
                    if (req[g] || pass[g]) m_idle[g] = 0;
                    else begin
                        m_idle[g]++;
                        if (m_idle[g] == Hold) begin
                            m_phase[g] = PhDown;
                            m_left[g]  = Move;
                        end
                    end
                end
                default: begin
                    if (pass[g]) begin
                        m_phase[g] = PhUp;
                        m_left[g]  = Move;
                    end else begin
                        m_left[g]--;
                        if (m_left[g] == 0) m_phase[g] = PhClosed;
                    end
                end
            endcase
            m_prev[g] = pass[g];
        end
        if (ev[0] && !ev[1] && m_count < Cap) m_count++;
        if (ev[1] && !ev[0] && m_count > 0) m_count--;
    endtask

    function automatic logic [10:0] model_outs();
        return {m_phase[0] == PhOpen, m_phase[0] == PhUp, m_phase[0] == PhDown,
                m_phase[1] == PhOpen, m_phase[1] == PhUp, m_phase[1] == PhDown,
                4'(m_count), m_count == Cap};
    endfunction

    task automatic cycle(input bit rst, input bit ir, input bit ip, input bit orq, input bit op);
        reset                 = rst;
        gate_bus.car_in_req   = ir;
        gate_bus.car_in_pass  = ip;
        gate_bus.car_out_req  = orq;
        gate_bus.car_out_pass = op;
        model_step(rst, ir, ip, orq, op);
        @(posedge clk_2);
        #1;
        check("model", dut_outs, model_outs());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    function automatic logic [10:0] ent(input bit cin, input bit up, input bit dn, input int cnt);
        return {cin, up, dn, 3'b000, 4'(cnt), 1'b0};
    endfunction

    task automatic add_vec(input bit rst, input bit ir, input bit ip, input logic [10:0] exp);
        vec_t v;
        v.rst = rst; v.ir = ir; v.ip = ip; v.orq = 1'b0; v.op = 1'b0; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        bit pi = 1'b0;
        bit po = 1'b0;

        // Single entry cycle, one row per clock.
        add_vec(1, 0, 0, ent(0, 0, 0, 0));
        add_vec(0, 1, 0, ent(0, 1, 0, 0));
        repeat (3) add_vec(0, 0, 0, ent(0, 1, 0, 0));
        add_vec(0, 0, 0, ent(1, 0, 0, 0));
        repeat (3) add_vec(0, 0, 1, ent(1, 0, 0, 0));
        repeat (7) add_vec(0, 0, 0, ent(1, 0, 0, 1));
        repeat (4) add_vec(0, 0, 0, ent(0, 0, 1, 1));
        add_vec(0, 0, 0, ent(0, 0, 0, 1));

        foreach (vecs[i]) begin
            cycle(vecs[i].rst, vecs[i].ir, vecs[i].ip, vecs[i].orq, vecs[i].op);
            check($sformatf("vec%0d", i), dut_outs, vecs[i].exp);
        end

        // Full lot: ten entries, refused request, one exit.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        idle(4);
        check("full_gate_open", gate_bus.cancela_entrada, 1);
        repeat (10) begin
            cycle(0, 0, 1, 0, 0);
            cycle(0, 0, 0, 0, 0);
        end
        check("full_count", gate_bus.num_carros, 10);
        check("full_flag", gate_bus.lot_full, 1);
        idle(14);
        check("full_closed", {gate_bus.cancela_entrada, gate_bus.motor_in_down}, 0);
        repeat (3) begin
            cycle(0, 1, 0, 0, 0);
            check("full_refuse", {gate_bus.motor_in_up, gate_bus.cancela_entrada}, 0);
        end
        idle(1);
        cycle(0, 0, 0, 1, 0);
        idle(4);
        check("exit_open", gate_bus.cancela_saida, 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);
        check("exit_count", gate_bus.num_carros, 9);
        check("exit_flag", gate_bus.lot_full, 0);
        idle(16);

        // Empty lot: exit request never raises the gate.
        cycle(1, 0, 0, 0, 0);
        repeat (6) begin
            cycle(0, 0, 0, 1, 0);
            check("empty_refuse", {gate_bus.motor_out_up, gate_bus.cancela_saida}, 0);
        end

        // Safety reversal on the second lowering cycle.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        idle(4);
        idle(8);
        check("rev_lowering", gate_bus.motor_in_down, 1);
        idle(1);
        cycle(0, 0, 1, 0, 0);
        check("rev_up", {gate_bus.motor_in_up, gate_bus.motor_in_down}, 2'b10);
        repeat (3) begin
            idle(1);
            check("rev_up_hold", gate_bus.motor_in_up, 1);
        end
        idle(1);
        check("rev_open", gate_bus.cancela_entrada, 1);
        check("rev_count", gate_bus.num_carros, 0);
        idle(14);

        // Simultaneous passages and tailgating.
        cycle(1, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0);
        idle(4);
        repeat (5) begin
            cycle(0, 1, 1, 0, 0);
            cycle(0, 1, 0, 0, 0);
        end
        check("sim_preload", gate_bus.num_carros, 5);
        cycle(0, 1, 0, 1, 0);
        repeat (4) cycle(0, 1, 0, 0, 0);
        check("sim_both_open", {gate_bus.cancela_entrada, gate_bus.cancela_saida}, 2'b11);
        cycle(0, 1, 1, 0, 1);
        cycle(0, 1, 0, 0, 0);
        check("sim_cancel", gate_bus.num_carros, 5);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0);
        check("tailgate", gate_bus.num_carros, 7);
        idle(20);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) pi = ~pi;
            if ($urandom_range(2) == 0) po = ~po;
            cycle($urandom_range(299) == 0, $urandom_range(2) == 0, pi,
                  $urandom_range(4) == 0, po);
        end

        // Reset mid-operation clears everything at once.
        cycle(0, 1, 0, 1, 0);
        idle(2);
        cycle(1, 1, 1, 1, 1);
        check("reset_mid", dut_outs, 11'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
